// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the requester-side front end of the 1024x32
// dual-port synchronous memory: geometry, the memory's access key, the
// error-counter width and the initiator FSM state encoding.
package mem_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int KEY_W    = 16;
  localparam int ERRCNT_W = 8;

  localparam logic [KEY_W-1:0] ACCESS_KEY = 16'h0032;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter. It counts one per cycle while inc is high and
// holds at all-ones once it gets there.
// Ports:
//   clk    in   clock, posedge
//   rst_n  in   asynchronous active-low reset, clears count
//   inc    in   increment request for this cycle
//   count  out  current count
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_initiator.sv
// mem_access_initiator
// Requester-side front end for the 1024x32 dual-port synchronous memory
// (registered 1-cycle read). It takes one read/write request at a time,
// checks the request key against the memory key, drives the memory write
// or read port for exactly one cycle, and returns a held response.
//
// Handshakes (request and response sides alike): a transfer happens on a
// posedge where valid && ready are both high. The producer holds valid and
// its payload stable until that edge; ready may be driven freely. Here
// req_ready is high only in IDLE, and rsp_valid with rsp_data/rsp_err is
// held in RESP until the consumer takes it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_write, req_addr,
//   req_wdata, req_key         request payload
//   mem_we/mem_waddr/mem_wdata memory write port
//   mem_re/mem_raddr           memory read port
//   mem_rdata                  memory read data, valid the cycle after mem_re
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_err          response payload (data is 0 for writes/errors)
//   err_count                  saturating count of key mismatches
//
// Timing from accept cycle N: key error responds at N+1, write strobes at
// N+1 and responds at N+2, read strobes at N+1, captures at N+2 and
// responds at N+3.
module mem_access_initiator
  import mem_pkg::*;
#(
  parameter int                     ADDR_W     = mem_pkg::ADDR_W,
  parameter int                     DATA_W     = mem_pkg::DATA_W,
  parameter int                     KEY_W      = mem_pkg::KEY_W,
  parameter logic [KEY_W-1:0]       ACCESS_KEY = mem_pkg::ACCESS_KEY,
  parameter int                     ERRCNT_W   = mem_pkg::ERRCNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [KEY_W-1:0]    req_key,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_re,
  output logic [ADDR_W-1:0]   mem_raddr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_count
);

  // FSM state is kept as a plain named signal so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;

  logic accept;
  logic key_match;
  logic key_error;

  assign accept    = req_valid && req_ready;
  assign key_match = (req_key == ACCESS_KEY);
  assign key_error = accept && !key_match;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and state-decoded outputs. Strobes decode straight from the
  // state register, so an asynchronous reset drops them at once and they
  // can never be high outside ISSUE or together.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    rsp_valid  = 1'b0;

    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = key_match ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        mem_we     = write_q;
        mem_re     = !write_q;
        state_next = write_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        // Going back to IDLE on the handshake means req_ready only rises
        // the cycle after, so no accept can coincide with the response.
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_waddr = addr_q;
  assign mem_raddr = addr_q;
  assign mem_wdata = wdata_q;

  // ---------------------------------------------------------------------
  // Request capture and response payload
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      write_q  <= req_write;
      // Writes and key errors answer with zero data; reads overwrite this
      // in CAPTURE.
      rsp_data <= '0;
      rsp_err  <= !key_match;
    end else if (state == CAPTURE) begin
      rsp_data <= mem_rdata;
    end
  end

  sat_counter #(
    .WIDTH (ERRCNT_W)
  ) u_err_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (key_error),
    .count (err_count)
  );

endmodule
